dist_calc_scheduler: RTL and testbench

- Shares one horizontal-distance calculator between N requesters using round-robin arbitration.
- Accepts a request and latches its operand onto the calculator input bus.
- Sequences the calculator's start-high/start-low handshake, tracks its done flag through clear and set, and returns the result to the granted requester on a valid/ready channel.
- Sits between requester blocks and the calculator's control unit/datapath.

---
 rtl/dist_calc_scheduler.sv | 180 ++++++++++++++++++
 tb/tb_dist_calc_scheduler.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dist_calc_scheduler.sv
// Round-robin scheduler sharing one horizontal-distance calculator between N requesters.
// Optional wait-state timeout is enabled by defining DIST_SCHED_TIMEOUT_EN.
module dist_calc_scheduler #(
  parameter int unsigned N           = 4,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned RES_W       = 32,
  parameter int unsigned START_HOLD  = 4,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N-1:0]        req,
  input  logic [N*DATA_W-1:0] req_data,
  output logic [N-1:0]        gnt,
  output logic [N-1:0]        rsp_valid,
  input  logic [N-1:0]        rsp_ready,
  output logic [RES_W-1:0]    rsp_data,
  output logic                rsp_err,
  output logic                calc_start,
  output logic [DATA_W-1:0]   calc_x,
  input  logic                calc_done,
  input  logic [RES_W-1:0]    calc_result,
  output logic                busy
);

  localparam int unsigned IW = $clog2(N);
  localparam int unsigned CW = $clog2(START_HOLD);

  if (N < 2 || N > 8 || START_HOLD < 2 || TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_param_check
    $error("dist_calc_scheduler: parameter out of range");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_GRANT, S_START_HI, S_START_LO, S_WAIT_CLR, S_WAIT_SET, S_RESP
  } state_t;

  state_t             state_q;
  logic [IW-1:0]      owner_q;
  logic [IW-1:0]      rr_ptr_q;
  logic [CW-1:0]      cnt_q;
  logic [N-1:0]       gnt_q;
  logic [N-1:0]       rsp_valid_q;
  logic [RES_W-1:0]   rsp_data_q;
  logic               calc_start_q;
  logic [DATA_W-1:0]  calc_x_q;
  logic               busy_q;

  logic [IW-1:0]      pick_d;
  logic               pick_vld_d;
  logic [N-1:0]       owner_oh;
  logic               hold_last;

  // First requester after rr_ptr_q, wrapping modulo N, so the last served ranks lowest.
  always_comb begin : arb
    int unsigned idx;
    pick_d     = '0;
    pick_vld_d = 1'b0;
    idx        = 0;
    for (int unsigned k = 1; k <= N; k++) begin
      idx = (32'(rr_ptr_q) + k) % N;
      if (!pick_vld_d && req[IW'(idx)]) begin
        pick_d     = IW'(idx);
        pick_vld_d = 1'b1;
      end
    end
  end

  assign owner_oh  = N'(1) << owner_q;
  assign hold_last = (cnt_q == CW'(START_HOLD - 1));

`ifdef DIST_SCHED_TIMEOUT_EN
  localparam int unsigned TW = (TIMEOUT_CYC > 255) ? 16 : 8;
  logic [TW-1:0] wait_cnt_q;
  logic [TW-1:0] wait_cnt_d;
  logic          rsp_err_q;
  logic          timeout_d;

  assign wait_cnt_d = (wait_cnt_q == '1) ? wait_cnt_q : wait_cnt_q + 1'b1;
  assign timeout_d  = (32'(wait_cnt_d) >= TIMEOUT_CYC);
  assign rsp_err    = rsp_err_q;
`else
  assign rsp_err    = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      owner_q      <= '0;
      rr_ptr_q     <= IW'(N - 1);
      cnt_q        <= '0;
      gnt_q        <= '0;
      rsp_valid_q  <= '0;
      rsp_data_q   <= '0;
      calc_start_q <= 1'b0;
      calc_x_q     <= '0;
      busy_q       <= 1'b0;
`ifdef DIST_SCHED_TIMEOUT_EN
      wait_cnt_q   <= '0;
      rsp_err_q    <= 1'b0;
`endif
    end else begin
      gnt_q <= '0;
      unique case (state_q)
        S_IDLE: if (pick_vld_d) begin
          owner_q <= pick_d;
          gnt_q   <= N'(1) << pick_d;
          busy_q  <= 1'b1;
          state_q <= S_GRANT;
        end
        S_GRANT: begin
          calc_x_q     <= req_data[owner_q*DATA_W +: DATA_W];
          rr_ptr_q     <= owner_q;
          calc_start_q <= 1'b1;
          cnt_q        <= '0;
          state_q      <= S_START_HI;
        end
        S_START_HI: begin
          cnt_q <= hold_last ? '0 : cnt_q + 1'b1;
          if (hold_last) begin
            calc_start_q <= 1'b0;
            state_q      <= S_START_LO;
          end
        end
        S_START_LO: begin
          cnt_q <= hold_last ? '0 : cnt_q + 1'b1;
          if (hold_last) begin
`ifdef DIST_SCHED_TIMEOUT_EN
            wait_cnt_q <= '0;
`endif
            state_q <= S_WAIT_CLR;
          end
        end
        S_WAIT_CLR: begin
`ifdef DIST_SCHED_TIMEOUT_EN
          wait_cnt_q <= wait_cnt_d;
          if (timeout_d) begin
            rsp_data_q  <= '1;
            rsp_err_q   <= 1'b1;
            rsp_valid_q <= owner_oh;
            state_q     <= S_RESP;
          end else
`endif
          if (!calc_done) state_q <= S_WAIT_SET;
        end
        S_WAIT_SET: begin
          if (calc_done) begin
            rsp_data_q  <= calc_result;
            rsp_valid_q <= owner_oh;
            state_q     <= S_RESP;
`ifdef DIST_SCHED_TIMEOUT_EN
            rsp_err_q   <= 1'b0;
          end else if (timeout_d) begin
            rsp_data_q  <= '1;
            rsp_err_q   <= 1'b1;
            rsp_valid_q <= owner_oh;
            state_q     <= S_RESP;
`endif
          end
`ifdef DIST_SCHED_TIMEOUT_EN
          wait_cnt_q <= wait_cnt_d;
`endif
        end
        S_RESP: if (rsp_ready[owner_q]) begin
          rsp_valid_q <= '0;
          busy_q      <= 1'b0;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign gnt        = gnt_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign calc_start = calc_start_q;
  assign calc_x     = calc_x_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_dist_calc_scheduler.sv
// Bench for dist_calc_scheduler: directed job table, hand-written reset/timeout sequences, random jobs.
module tb_dist_calc_scheduler;
  localparam int unsigned N  = 4;
  localparam int unsigned DW = 16;
  localparam int unsigned RW = 32;
  localparam int unsigned SH = 4;
  localparam int unsigned TO = 50;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  req, gnt, rsp_valid, rsp_ready;
  logic [N*DW-1:0] req_data;
  logic [RW-1:0] rsp_data, calc_result;
  logic          rsp_err, calc_start, calc_done, busy;
  logic [DW-1:0] calc_x;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;
  int unsigned last_srv;

  typedef struct {
    logic [N-1:0]    mask;
    logic [N*DW-1:0] data;
    bit              stale;
    int unsigned     c;
    int unsigned     d;
    int unsigned     rdly;
    logic [RW-1:0]   result;
    int unsigned     owner;
  } job_t;

  job_t tbl[9];

  always #5 clk = ~clk;

  dist_calc_scheduler #(.N(N), .DATA_W(DW), .RES_W(RW), .START_HOLD(SH), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data), .gnt(gnt),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .calc_start(calc_start), .calc_x(calc_x), .calc_done(calc_done),
    .calc_result(calc_result), .busy(busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference arbitration: next requester after the last one served, modulo N.
  function automatic int unsigned rr_pick(input logic [N-1:0] m, input int unsigned last);
    for (int unsigned k = 1; k <= N; k++)
      if (m[(last + k) % N]) return (last + k) % N;
    return 0;
  endfunction

  task automatic wait_gnt(input logic [N-1:0] oh);
    int unsigned n = 0;
    while (gnt == '0 && n < 8) begin
      tick();
      n++;
    end
    check("gnt", gnt, oh);
    check("gnt_busy", busy, 1);
  endtask

  task automatic run_job(input job_t j);
    logic [DW-1:0] xv;
    logic [N-1:0]  oh;
    oh = '0;
    oh[j.owner] = 1'b1;
    xv = j.data[j.owner*DW +: DW];
    req = j.mask;
    req_data = j.data;
    rsp_ready = '0;
    calc_result = $urandom;
    wait_gnt(oh);
    req[j.owner] = 1'b0;
    calc_done = j.stale;
    for (int i = 0; i < SH; i++) begin
      tick();
      check("start_hi", calc_start, 1);
      check("calc_x", calc_x, xv);
    end
    for (int i = 0; i < SH; i++) begin
      tick();
      check("start_lo", calc_start, 0);
    end
    if (j.stale) begin
      for (int i = 0; i < j.c; i++) begin
        tick();
        check("early_rsp", rsp_valid, 0);
      end
      calc_done = 1'b0;
    end
    for (int i = 0; i < j.d; i++) begin
      tick();
      check("early_rsp", rsp_valid, 0);
    end
    calc_result = j.result;
    calc_done = 1'b1;
    tick();
    check("rsp_valid", rsp_valid, oh);
    check("rsp_data", rsp_data, j.result);
    check("rsp_err", rsp_err, 0);
    calc_result = ~j.result;
    rsp_ready = N'($urandom) & ~oh;
    for (int i = 0; i < j.rdly; i++) begin
      tick();
      check("hold_valid", rsp_valid, oh);
      check("hold_data", rsp_data, j.result);
      check("hold_busy", busy, 1);
      check("no_gnt", gnt, 0);
    end
    rsp_ready = oh;
    tick();
    check("rsp_clear", rsp_valid, 0);
    check("idle_busy", busy, 0);
    rsp_ready = '0;
    last_srv = j.owner;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    job_t        j;
    logic [N-1:0] pend;

    tbl[0] = '{4'b1111, {16'd40, 16'd30, 16'd20, 16'd10}, 1'b0, 0, 2, 0,  32'h0000_0A01, 0};
    tbl[1] = '{4'b1111, {16'd41, 16'd31, 16'd21, 16'd11}, 1'b0, 0, 3, 1,  32'h0000_0A02, 1};
    tbl[2] = '{4'b1111, {16'd42, 16'd32, 16'd22, 16'd12}, 1'b1, 2, 2, 0,  32'h0000_0A03, 2};
    tbl[3] = '{4'b1111, {16'd43, 16'd33, 16'd23, 16'd13}, 1'b0, 0, 4, 2,  32'hA5A5_0004, 3};
    tbl[4] = '{4'b1111, {16'd44, 16'd34, 16'd24, 16'd14}, 1'b0, 0, 2, 0,  32'h8000_0001, 0};
    tbl[5] = '{4'b0010, {16'd7,  16'd6,  16'd100, 16'd5}, 1'b0, 0, 3, 0,  32'h0000_1234, 1};
    tbl[6] = '{4'b1101, {16'hBEEF, 16'hCAFE, 16'h0123, 16'h4567}, 1'b0, 0, 2, 20, 32'h0000_5555, 2};
    tbl[7] = '{4'b1001, {16'h00F3, 16'h00F2, 16'h00F1, 16'h00F0}, 1'b0, 0, 2, 1, 32'hFFFF_0000, 3};
    tbl[8] = '{4'b0001, {16'd3, 16'd2, 16'd1, 16'd9}, 1'b1, 3, 10, 0, 32'd7, 0};

    reset = 1'b0;
    req = '0;
    req_data = '0;
    rsp_ready = '0;
    calc_done = 1'b1;
    calc_result = '0;
    last_srv = N - 1;
    tick();
    tick();
    check("rst_gnt", gnt, 0);
    check("rst_valid", rsp_valid, 0);
    check("rst_data", rsp_data, 0);
    check("rst_err", rsp_err, 0);
    check("rst_start", calc_start, 0);
    check("rst_x", calc_x, 0);
    check("rst_busy", busy, 0);
    reset = 1'b1;
    tick();

    for (int r = 0; r < 9; r++) begin
      check("tbl_model", rr_pick(tbl[r].mask, last_srv), tbl[r].owner);
      run_job(tbl[r]);
    end

    // Reset while waiting for done: everything clears immediately and arbitration restarts.
    req = 4'b0100;
    req_data = {16'd1, 16'd555, 16'd2, 16'd3};
    wait_gnt(4'b0100);
    req = '0;
    calc_done = 1'b0;
    repeat (2 * SH + 2) tick();
    check("mid_valid", rsp_valid, 0);
    #2 reset = 1'b0;
    #1;
    check("mrst_gnt", gnt, 0);
    check("mrst_valid", rsp_valid, 0);
    check("mrst_data", rsp_data, 0);
    check("mrst_err", rsp_err, 0);
    check("mrst_start", calc_start, 0);
    check("mrst_x", calc_x, 0);
    check("mrst_busy", busy, 0);
    tick();
    reset = 1'b1;
    last_srv = N - 1;
    j = '{4'b1100, {16'd77, 16'd66, 16'd55, 16'd44}, 1'b0, 0, 2, 1, 32'h0BAD_F00D, 0};
    j.owner = rr_pick(j.mask, last_srv);
    check("post_rst_model", j.owner, 2);
    run_job(j);

`ifdef DIST_SCHED_TIMEOUT_EN
    req = 4'b0001;
    req_data = {16'd0, 16'd0, 16'd0, 16'd321};
    wait_gnt(4'b0001);
    req = '0;
    calc_done = 1'b0;
    repeat (2 * SH) tick();
    for (int i = 0; i < TO; i++) begin
      tick();
      check("to_wait", rsp_valid, 0);
    end
    tick();
    check("to_valid", rsp_valid, 4'b0001);
    check("to_err", rsp_err, 1);
    check("to_data", rsp_data, 32'hFFFF_FFFF);
    rsp_ready = 4'b0001;
    tick();
    check("to_clear", rsp_valid, 0);
    rsp_ready = '0;
    last_srv = 0;
`endif

    pend = '0;
    for (int r = 0; r < 30; r++) begin
      pend = pend | N'($urandom);
      if (pend == '0) pend[$urandom_range(N - 1, 0)] = 1'b1;
      j.mask   = pend;
      j.data   = {$urandom, $urandom};
      j.stale  = 1'($urandom_range(1, 0));
      j.c      = $urandom_range(5, 1);
      j.d      = $urandom_range(8, 2);
      j.rdly   = $urandom_range(4, 0);
      j.result = $urandom;
      j.owner  = rr_pick(pend, last_srv);
      run_job(j);
      pend[j.owner] = 1'b0;
    end

    req = '0;
    tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
